result_demux: RTL
=================

Name: result_demux

Overview:
- Steering block, the inverse of the datapath 2:1 selector.
- Takes one stream of 32-bit results, e.g. the execute/memory result, and routes each word to one of two consumers, selected per word by in_sel. Example consumers: GPR writeback (port 0) and HI/LO unit (port 1).
- Each destination has an independent 2-entry FIFO with valid/ready handshakes, so a stalled consumer never blocks words bound for the other.

Parameters:
- SIZE, 31: MSB index of the data path; data width is SIZE+1.

Ports:
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word on in_data
- in_sel  input  1  destination of current word: 0 = port 0, 1 = port 1
- in_data  input  SIZE+1  word to route
- in_ready  output  1  demux accepts the word this cycle
- out0_valid  output  1  port 0 FIFO head valid
- out0_data  output  SIZE+1  port 0 FIFO head
- out0_ready  input  1  port 0 consumer takes head this cycle
- out1_valid  output  1  port 1 FIFO head valid
- out1_data  output  SIZE+1  port 1 FIFO head
- out1_ready  input  1  port 1 consumer takes head this cycle
- occ0  output  2  port 0 FIFO occupancy, 0..2
- occ1  output  2  port 1 FIFO occupancy, 0..2

Behaviour:
- Reset:
  - One clock; reset asynchronous, active-low on rst_n.
  - While rst_n = 0: occ0 = occ1 = 0, out0_valid = out1_valid = 0, out0_data = out1_data = 0, all storage and pointers = 0, in_ready = 0.
  - After release, in_ready rises combinationally (both FIFOs empty).
- Ready rule:
  - in_ready = rst_n && (in_sel ? occ1 != 2 : occ0 != 2).
  - It depends only on registered occupancy and in_sel. There is no combinational path from out*_ready to in_ready.
- Push:
  - Occurs when in_valid && in_ready at a rising edge.
  - in_data is written at the selected FIFO's write pointer; that pointer toggles (1-bit, wraps 1 -> 0).
  - The unselected FIFO is untouched.
- Pop (port k):
  - Occurs when outk_valid && outk_ready at a rising edge; that read pointer toggles.
  - outk_ready while outk_valid = 0 is ignored.
- Outputs:
  - outk_valid = (occk != 0).
  - outk_data = entry at read pointer when valid, else 0.
  - Both are driven from registered state only.
- Occupancy update per port, per edge:
  - push only: +1
  - pop only: -1
  - push and pop together (only possible when occ = 1): unchanged, and data ordering is preserved.
- Latency:
  - A word accepted at edge N appears on outk_data/outk_valid after edge N.
  - Empty-FIFO throughput is one word per cycle per port.
- Ordering:
  - FIFO order is preserved within each port.
  - There is no ordering relation between ports.
- Full:
  - With occk = 2, a word selecting port k is held off (in_ready = 0) even if outk_ready = 1 that cycle.
  - The producer must hold in_valid, in_sel and in_data stable until accepted.
- in_valid = 0: no push, regardless of in_sel.
- Reset mid-operation: the asynchronous assertion immediately empties both FIFOs. Buffered words are discarded, not delivered.
- X on in_sel while in_valid = 0 must not corrupt state.

Test Plan:
- Reset, then in_valid = 1, in_sel = 0, in_data = 32'h0000_00AA, out0_ready = 0 for one edge -> out0_valid = 1, out0_data = AA, occ0 = 1, out1_valid = 0, occ1 = 0.
- Push 11, 22 to port 0 with out0_ready = 0, then present 33 to port 0 -> in_ready = 0, occ0 = 2. Raise out0_ready for one edge -> 11 popped, occ0 = 2→1, 33 not accepted that edge. 33 is accepted next edge; pops yield 22 then 33.
- Port 0 full and stalled; present 55 with in_sel = 1 -> in_ready = 1, out1_data = 55 next cycle, port 0 contents unchanged.
- occ1 = 1 holding 66; same edge push 77 to port 1 and out1_ready = 1 -> occ1 stays 1, out1_data = 77.
- Alternate in_sel 0/1 with 10 words A0..A9 and both readies = 1 -> port 0 delivers A0, A2, A4, A6, A8 and port 1 delivers A1, A3, A5, A7, A9, one per cycle, latency 1.
- Fill both FIFOs (occ0 = occ1 = 2), assert rst_n = 0 mid-cycle -> valids, occs and data drop to 0 without waiting for a clock edge, in_ready = 0. After release, the first push is delivered correctly.

Source files
------------

// File: rtl/result_demux.sv
// result_demux
//
// Purpose:
//     Steers a single stream of result words to one of two consumers. The
//     in_sel bit that comes with each word picks the consumer. Port 0 might be
//     the GPR writeback path and port 1 the HI/LO unit. Each port has its own
//     2-entry FIFO, so a stalled consumer never holds up words going to the
//     other port.
//
// Parameters:
//     SIZE        MSB index of the data path (data width is SIZE+1)
//
// Ports:
//     clk         rising-edge clock for all state
//     rst_n       asynchronous active-low reset
//     in_valid    producer has a word on in_data
//     in_sel      destination of the current word (0 = port 0, 1 = port 1)
//     in_data     word to route
//     in_ready    demux accepts the word this cycle
//     out0_valid  port 0 FIFO head valid
//     out0_data   port 0 FIFO head (zero when empty)
//     out0_ready  port 0 consumer takes the head this cycle
//     out1_valid  port 1 FIFO head valid
//     out1_data   port 1 FIFO head (zero when empty)
//     out1_ready  port 1 consumer takes the head this cycle
//     occ0        port 0 FIFO occupancy, 0..2
//     occ1        port 1 FIFO occupancy, 0..2

module result_demux #(
    parameter int SIZE = 31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_sel,
    input  logic [SIZE:0]   in_data,
    output logic            in_ready,
    output logic            out0_valid,
    output logic [SIZE:0]   out0_data,
    input  logic            out0_ready,
    output logic            out1_valid,
    output logic [SIZE:0]   out1_data,
    input  logic            out1_ready,
    output logic [1:0]      occ0,
    output logic [1:0]      occ1
);

    // Storage and pointers are indexed [port][entry]. Each pointer is a
    // single bit because each FIFO holds only two entries.
    logic [SIZE:0] mem_q [2][2];
    logic [SIZE:0] mem_d [2][2];
    logic [1:0]    wptr_q, wptr_d;
    logic [1:0]    rptr_q, rptr_d;
    logic [1:0]    occ_q [2];
    logic [1:0]    occ_d [2];

    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    out_valid;
    logic [1:0]    out_ready;

    assign out_ready = {out1_ready, out0_ready};

    // in_ready looks only at registered occupancy. It never looks at the
    // consumer readies, so a full port stays closed even in a cycle where
    // its consumer drains. Including rst_n holds it low during reset.
    assign in_ready = rst_n && (in_sel ? (occ_q[1] != 2'd2) : (occ_q[0] != 2'd2));

    // in_valid gates both pushes. An unknown in_sel while in_valid is low
    // therefore cannot write either FIFO.
    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        occ_d     = occ_q;
        push      = 2'b00;
        pop       = 2'b00;
        out_valid = 2'b00;

        push[0] = in_valid && in_ready && !in_sel;
        push[1] = in_valid && in_ready && in_sel;

        for (int p = 0; p < 2; p++) begin
            out_valid[p] = (occ_q[p] != 2'd0);
            pop[p]       = out_valid[p] && out_ready[p];

            if (push[p]) begin
                mem_d[p][wptr_q[p]] = in_data;
                wptr_d[p]           = ~wptr_q[p];
            end

            if (pop[p]) begin
                rptr_d[p] = ~rptr_q[p];
            end

            // A push and a pop in the same cycle can only happen at
            // occupancy 1. The push goes to the other slot, so occupancy
            // stays the same and word order is kept.
            case ({push[p], pop[p]})
                2'b10:   occ_d[p] = occ_q[p] + 2'd1;
                2'b01:   occ_d[p] = occ_q[p] - 2'd1;
                default: occ_d[p] = occ_q[p];
            endcase
        end
    end

    // Asserting reset clears both FIFOs at once. Any buffered words are
    // dropped and never delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int e = 0; e < 2; e++) begin
                    mem_q[p][e] <= '0;
                end
                occ_q[p] <= 2'd0;
            end
            wptr_q <= 2'b00;
            rptr_q <= 2'b00;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Output data is forced to zero when a port is empty, so a stale entry
    // never shows up on the bus.
    assign out0_valid = out_valid[0];
    assign out1_valid = out_valid[1];
    assign out0_data  = out_valid[0] ? mem_q[0][rptr_q[0]] : '0;
    assign out1_data  = out_valid[1] ? mem_q[1][rptr_q[1]] : '0;
    assign occ0       = occ_q[0];
    assign occ1       = occ_q[1];

endmodule
